hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL: parameter REG_AW, 5, register-address width.
REQ-002 SHALL: parameter MDU_LATENCY, 4, multiply/divide busy cycles after issue; legal range 1..15.
REQ-003 SHALL: clk  input  1  sole clock; reset is synchronous and active-high, sampled on the rising edge of clk.
REQ-004 SHALL: reset  input  1  synchronous active-high reset.
REQ-005 SHALL: id_rs, id_rt  input  REG_AW each  source registers of the instruction in ID.
REQ-006 SHALL: id_use_rs, id_use_rt  input  1 each  the ID instruction actually reads that source.
REQ-007 SHALL: id_branch  input  1  the ID instruction is a branch or jr resolved in ID.
REQ-008 SHALL: id_mdu_start, id_mdu_read  input  1 each  the ID instruction is mult/div, or mfhi/mflo.
REQ-009 SHALL: ex_reg_write, ex_mem_read  input  1 each  ID/EX control bits; ex_dst  input  REG_AW  post-mux destination register.
REQ-010 SHALL: mem_mem_read  input  1, mem_dst  input  REG_AW  EX/MEM load flag and destination register.
REQ-011 SHALL: branch_taken  input  1  ID branch resolved taken.
REQ-012 SHALL: pc_write, if_id_write  output  1 each  enables; id_ex_bubble, if_id_flush  output  1 each.
REQ-013 SHALL: mdu_busy  output  1; stall_cause  output  2  0 none, 1 load-use, 2 branch-data, 3 MDU.

Function
REQ-014 SHALL: a match is a source in use, equal to the compared destination, and that destination nonzero; register 0 never causes a hazard.
REQ-015 SHALL: load-use stall when ex_mem_read and ex_dst matches; cause 1.
REQ-016 SHALL: branch-data stall when id_branch and either ex_reg_write with ex_dst matching, or mem_mem_read with mem_dst matching; cause 2.
REQ-017 SHALL: MDU stall when mdu_busy and (id_mdu_read or id_mdu_start); cause 3.
REQ-018 SHALL: priority of stall_cause is 1 > 2 > 3 when several conditions hold.
REQ-019 SHALL: on any stall, pc_write=0, if_id_write=0 and id_ex_bubble=1 in the same cycle (combinational from inputs and the counter).
REQ-020 SHALL: if_id_flush = branch_taken AND no stall; a taken branch during a stall is ignored that cycle.
REQ-021 SHALL: a 4-bit counter mdu_cnt is loaded with MDU_LATENCY on a clock edge where id_mdu_start is high and no stall is active.
REQ-022 SHALL: otherwise mdu_cnt decrements by one while nonzero and holds at zero; mdu_busy = (mdu_cnt != 0).
REQ-023 SHALL: an accepted MDU start when mdu_cnt==1 reloads to MDU_LATENCY with no idle gap; a start while mdu_cnt>1 stalls.
REQ-024 SHALL: a rejected (stalled) id_mdu_start never loads the counter.
REQ-025 SHALL: with no stall, outputs are pc_write=1, if_id_write=1, id_ex_bubble=0, stall_cause=0.

Reset
REQ-026 SHALL: while reset is high, mdu_cnt clears to 0 on the edge, and pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, mdu_busy=0, stall_cause=0 regardless of the other inputs.
REQ-027 SHALL: reset asserted mid-MDU operation aborts it; mdu_busy=0 in the first cycle after the reset edge.

Configuration
REQ-028 SHALL: with HAZARD_PERF_CNT_EN defined, outputs stall_cycles and flush_count (32 bits each) are present: stall_cycles increments on each edge with pc_write=0, flush_count increments on each edge with if_id_flush=1, both saturate at 32'hFFFFFFFF and clear on reset.
REQ-029 SHALL: without HAZARD_PERF_CNT_EN, those ports and registers do not exist and all other behaviour is identical.

Verification
REQ-030 SHALL: lw $2 in EX (ex_mem_read=1, ex_dst=2), ID uses rs=2 -> one cycle pc_write=0, id_ex_bubble=1, stall_cause=1.
REQ-031 SHALL: beq $1,$2 in ID, ALU write to ex_dst=1 -> 1-cycle stall with cause 2; lw to $1 -> cause-1 stall, then cause-2 stall next cycle (mem_mem_read, mem_dst=1), then proceeds.
REQ-032 SHALL: ex_dst=0 with ex_mem_read=1 and id_rs=0 in use -> no stall.
REQ-033 SHALL: MDU_LATENCY=4, mult accepted, mflo next cycle -> mdu_busy high for 4 cycles, mflo stalled 4 cycles with cause 3, then issues.
REQ-034 SHALL: branch_taken=1 with no stall -> if_id_flush=1 (flush_count +1 when enabled); branch_taken=1 during load-use stall -> if_id_flush=0.
REQ-035 SHALL: reset pulsed at mdu_cnt=3 -> mdu_busy=0 the next cycle; a pending mflo issues without stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch-data and MDU-busy stalls, branch flush.
// Optional perf counters (stall_cycles, flush_count) when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MDU_LATENCY = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_id_use_rs,
    input  logic              i_id_use_rt,
    input  logic              i_id_branch,
    input  logic              i_id_mdu_start,
    input  logic              i_id_mdu_read,
    input  logic              i_ex_reg_write,
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_ex_dst,
    input  logic              i_mem_mem_read,
    input  logic [REG_AW-1:0] i_mem_dst,
    input  logic              i_branch_taken,
    output logic              o_pc_write,
    output logic              o_if_id_write,
    output logic              o_id_ex_bubble,
    output logic              o_if_id_flush,
    output logic              o_mdu_busy,
    output logic [1:0]        o_stall_cause
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       o_stall_cycles,
    output logic [31:0]       o_flush_count
`endif
);

    localparam logic [3:0] MduLat = 4'(MDU_LATENCY);

    logic [3:0] r_mdu_cnt;

    logic w_ex_match;
    logic w_mem_match;
    logic w_load_use;
    logic w_branch_data;
    logic w_mdu_haz;
    logic w_busy;
    logic w_stall;

    // Register 0 is hardwired, so a zero destination never creates a dependency.
    assign w_ex_match  = (i_ex_dst != '0) &&
                         ((i_id_use_rs && (i_id_rs == i_ex_dst)) ||
                          (i_id_use_rt && (i_id_rt == i_ex_dst)));
    assign w_mem_match = (i_mem_dst != '0) &&
                         ((i_id_use_rs && (i_id_rs == i_mem_dst)) ||
                          (i_id_use_rt && (i_id_rt == i_mem_dst)));

    assign w_busy        = (r_mdu_cnt != 4'd0);
    assign w_load_use    = i_ex_mem_read && w_ex_match;
    assign w_branch_data = i_id_branch &&
                           ((i_ex_reg_write && w_ex_match) || (i_mem_mem_read && w_mem_match));
    // A new start in the last busy cycle is accepted back-to-back; reads wait for idle.
    assign w_mdu_haz     = (w_busy && i_id_mdu_read) || ((r_mdu_cnt > 4'd1) && i_id_mdu_start);
    assign w_stall       = !i_reset && (w_load_use || w_branch_data || w_mdu_haz);

    always_comb begin
        o_pc_write     = 1'b1;
        o_if_id_write  = 1'b1;
        o_id_ex_bubble = 1'b0;
        o_if_id_flush  = 1'b0;
        o_mdu_busy     = 1'b0;
        o_stall_cause  = 2'd0;
        if (!i_reset) begin
            o_mdu_busy = w_busy;
            if (w_load_use) begin
                o_stall_cause = 2'd1;
            end else if (w_branch_data) begin
                o_stall_cause = 2'd2;
            end else if (w_mdu_haz) begin
                o_stall_cause = 2'd3;
            end
            if (w_stall) begin
                o_pc_write     = 1'b0;
                o_if_id_write  = 1'b0;
                o_id_ex_bubble = 1'b1;
            end else begin
                o_if_id_flush = i_branch_taken;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mdu_cnt <= 4'd0;
        end else if (i_id_mdu_start && !w_stall) begin
            r_mdu_cnt <= MduLat;
        end else if (w_busy) begin
            r_mdu_cnt <= r_mdu_cnt - 4'd1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (!o_pc_write && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (o_if_id_flush && (r_flush_count != 32'hFFFF_FFFF)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random stimulus
// compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned AW  = 5;
    localparam int unsigned LAT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] id_rs, id_rt, ex_dst, mem_dst;
    logic          use_rs, use_rt, branch, mdu_start, mdu_read;
    logic          ex_reg_write, ex_mem_read, mem_mem_read, branch_taken;
    logic          pc_write, if_id_write, id_ex_bubble, if_id_flush, mdu_busy;
    logic [1:0]    stall_cause;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   stall_cycles, flush_count;
`endif

    hazard_ctrl #(.REG_AW(AW), .MDU_LATENCY(LAT)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_id_use_rs    (use_rs),
        .i_id_use_rt    (use_rt),
        .i_id_branch    (branch),
        .i_id_mdu_start (mdu_start),
        .i_id_mdu_read  (mdu_read),
        .i_ex_reg_write (ex_reg_write),
        .i_ex_mem_read  (ex_mem_read),
        .i_ex_dst       (ex_dst),
        .i_mem_mem_read (mem_mem_read),
        .i_mem_dst      (mem_dst),
        .i_branch_taken (branch_taken),
        .o_pc_write     (pc_write),
        .o_if_id_write  (if_id_write),
        .o_id_ex_bubble (id_ex_bubble),
        .o_if_id_flush  (if_id_flush),
        .o_mdu_busy     (mdu_busy),
        .o_stall_cause  (stall_cause)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .o_stall_cycles (stall_cycles),
        .o_flush_count  (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: busy cycles left on the multiply/divide unit, perf totals.
    int          mdu_left = 0;
    longint      exp_stalls = 0;
    longint      exp_flushes = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit dep(input logic [AW-1:0] src, input logic used,
                               input logic [AW-1:0] dst);
        return used && (src == dst) && (dst != 0);
    endfunction

    function automatic int model_cause();
        bit ex_dep, mem_dep;
        if (reset) return 0;
        ex_dep  = dep(id_rs, use_rs, ex_dst) || dep(id_rt, use_rt, ex_dst);
        mem_dep = dep(id_rs, use_rs, mem_dst) || dep(id_rt, use_rt, mem_dst);
        if (ex_mem_read && ex_dep) return 1;
        if (branch && ((ex_reg_write && ex_dep) || (mem_mem_read && mem_dep))) return 2;
        if ((mdu_read && mdu_left > 0) || (mdu_start && mdu_left > 1)) return 3;
        return 0;
    endfunction

    // Called half a cycle before the rising edge: check outputs, then advance the model.
    task automatic step(input string tag, output logic pw);
        int  cause;
        bit  stall, flush;
        #1;
        cause = model_cause();
        stall = (cause != 0);
        flush = !reset && !stall && branch_taken;
        check_eq({tag, ".cause"}, 32'(stall_cause), 32'(cause));
        check_eq({tag, ".pcw"},   32'({pc_write, if_id_write, id_ex_bubble}),
                 stall ? 32'b001 : 32'b110);
        check_eq({tag, ".flush"}, 32'(if_id_flush), 32'(flush));
        check_eq({tag, ".busy"},  32'(mdu_busy), 32'(!reset && mdu_left > 0));
`ifdef HAZARD_PERF_CNT_EN
        check_eq({tag, ".stallcnt"}, stall_cycles, 32'(exp_stalls));
        check_eq({tag, ".flushcnt"}, flush_count, 32'(exp_flushes));
`endif
        pw = pc_write;
        @(posedge clk);
        if (reset) begin
            mdu_left = 0; exp_stalls = 0; exp_flushes = 0;
        end else begin
            if (stall) exp_stalls++;
            if (flush) exp_flushes++;
            if (mdu_start && !stall) mdu_left = LAT;
            else if (mdu_left > 0) mdu_left--;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset = 0; id_rs = 0; id_rt = 0; ex_dst = 0; mem_dst = 0;
        use_rs = 0; use_rt = 0; branch = 0; mdu_start = 0; mdu_read = 0;
        ex_reg_write = 0; ex_mem_read = 0; mem_mem_read = 0; branch_taken = 0;
    endtask

    task automatic rand_inputs();
        id_rs  = AW'($urandom_range(0, 3));
        id_rt  = AW'($urandom_range(0, 3));
        ex_dst = AW'($urandom_range(0, 3));
        mem_dst = AW'($urandom_range(0, 3));
        use_rs = 1'($urandom); use_rt = 1'($urandom); branch = 1'($urandom);
        mdu_start    = ($urandom_range(0, 3) == 0);
        mdu_read     = ($urandom_range(0, 3) == 0);
        ex_reg_write = 1'($urandom);
        ex_mem_read  = ($urandom_range(0, 2) == 0);
        mem_mem_read = ($urandom_range(0, 2) == 0);
        branch_taken = 1'($urandom);
        reset        = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        logic pw;
        int   n_stalled;
        idle_inputs();
        reset = 1;
        @(negedge clk);
        // Reset forces idle outputs even with hazardous inputs present.
        rand_inputs(); reset = 1; ex_mem_read = 1; ex_dst = 2; id_rs = 2; use_rs = 1;
        step("reset", pw);
        step("reset2", pw);

        // Load-use on $2.
        idle_inputs(); ex_mem_read = 1; ex_dst = 2; id_rs = 2; use_rs = 1;
        step("loaduse", pw);
        check_eq("loaduse.stall", 32'(pw), 32'd0);

        // beq $1,$2 after ALU write to $1.
        idle_inputs(); branch = 1; id_rs = 1; id_rt = 2; use_rs = 1; use_rt = 1;
        ex_reg_write = 1; ex_dst = 1;
        step("br_alu", pw);
        // beq after lw $1: cause 1, then cause 2 from MEM, then proceed.
        ex_mem_read = 1; step("br_lw1", pw);
        ex_mem_read = 0; ex_reg_write = 0; ex_dst = 0; mem_mem_read = 1; mem_dst = 1;
        step("br_lw2", pw);
        mem_mem_read = 0; mem_dst = 0; step("br_lw3", pw);

        // Register 0 never hazards.
        idle_inputs(); ex_mem_read = 1; ex_dst = 0; id_rs = 0; use_rs = 1;
        step("r0", pw);

        // Taken branch: flush when free, ignored during load-use.
        idle_inputs(); branch_taken = 1; step("flush", pw);
        ex_mem_read = 1; ex_dst = 3; id_rt = 3; use_rt = 1; step("flush_stall", pw);

        // mult then mflo: mflo must stall exactly LAT cycles.
        idle_inputs(); mdu_start = 1; step("mult", pw);
        mdu_start = 0; mdu_read = 1; n_stalled = 0;
        for (int i = 0; i < 20; i++) begin
            step("mflo", pw);
            if (pw) break;
            n_stalled++;
        end
        check_eq("mflo.stall_len", 32'(n_stalled), 32'(LAT));

        // Back-to-back starts: reload on the last busy cycle.
        idle_inputs(); mdu_start = 1;
        for (int i = 0; i < 2 * LAT + 2; i++) step("mdu_b2b", pw);

        // Reset mid-operation aborts the MDU; pending mflo issues immediately.
        idle_inputs(); mdu_start = 1; step("mult2", pw);
        mdu_start = 0; step("mult2w", pw);
        reset = 1; mdu_read = 1; step("mdu_rst", pw);
        reset = 0; step("mflo_after_rst", pw);
        check_eq("mflo_after_rst.issue", 32'(pw), 32'd1);

        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            step("rand", pw);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
